// File: rtl/sram_axi_arbiter_pkg.sv
// Shared types and constants for the SRAM-to-AXI arbiter: FSM encodings,
// port ownership codes and the fixed AXI tie-off values.
package sram_axi_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_REQ,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        OWN_INST,
        OWN_DATA
    } owner_e;

    // Single-beat, single-ID traffic only.
    localparam logic [3:0] AXI_ID         = 4'd0;
    localparam logic [3:0] AXI_LEN        = 4'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic       AXI_LAST       = 1'b1;

    // SRAM size code (0/1/2) to AXI AxSIZE.
    function automatic logic [2:0] to_axsize(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/sram_axi_arbiter_if.sv
// Bundle of the two SRAM-like ports and the AXI3 master bus seen by the arbiter.
interface sram_axi_arbiter_if;
    import sram_axi_arbiter_pkg::*;

    // Instruction fetch port (read only)
    logic              inst_req;
    logic [1:0]        inst_size;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    // Data port (load/store)
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [STRB_W-1:0] data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    // AXI read channels
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rready;

    // AXI write channels
    logic [3:0]        awid;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [3:0]        wid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic              bvalid;
    logic              bready;

    // Arbiter side: serves the SRAM ports, masters the AXI bus.
    modport master (
        input  inst_req, inst_size, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready, rdata, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready, bvalid,
        output bready
    );

    // Environment side: CPU stages plus AXI slave.
    modport slave (
        output inst_req, inst_size, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready, rdata, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready, bvalid,
        input  bready
    );

endinterface

// File: rtl/sram_axi_arbiter_wr_channel.sv
// Write sequencer: one outstanding store, AW and W issued together and
// retired independently, then a single B response.
module sram_axi_arbiter_wr_channel
    import sram_axi_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    // Store acceptance strobe and its payload
    input  logic              accept,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [STRB_W-1:0] req_wstrb,
    input  logic [DATA_W-1:0] req_wdata,
    // Hold off B while the read path is returning data on the data port
    input  logic              b_block,
    output logic              idle,
    output logic              done,
    // AXI write channels
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    wr_state_e         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [DATA_W-1:0] wdata_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              aw_done_q;
    logic              w_done_q;

    // Write FSM with sticky per-channel completion flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= W_IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                W_IDLE: begin
                    if (accept) begin
                        addr_q    <= req_addr;
                        size_q    <= req_size;
                        wstrb_q   <= req_wstrb;
                        wdata_q   <= req_wdata;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (awvalid_q && awready) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (wvalid_q && wready) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    // Either flag may already be set, or both handshakes land now.
                    if ((aw_done_q || awready) && (w_done_q || wready)) begin
                        state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bvalid && bready) begin
                        state_q <= W_IDLE;
                    end
                end
                default: state_q <= W_IDLE;
            endcase
        end
    end

    assign idle    = (state_q == W_IDLE);
    assign bready  = (state_q == W_RESP) && !b_block;
    assign done    = bvalid && bready;
    assign awaddr  = addr_q;
    assign awsize  = to_axsize(size_q);
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wvalid  = wvalid_q;

endmodule

// File: rtl/sram_axi_arbiter.sv
// Shares one AXI3 master between the instruction-fetch and data SRAM ports:
// one outstanding read (data beats inst), one outstanding store, RAW blocking.
module sram_axi_arbiter
    import sram_axi_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    sram_axi_arbiter_if.master bus
);

    rd_state_e         rd_state_q;
    owner_e            owner_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [1:0]        arsize_q;
    logic              arvalid_q;
    logic              rready_q;

    logic              wr_idle;
    logic              wr_done;
    logic [ADDR_W-1:0] wr_addr;

    logic data_rd_req;
    logic data_wr_req;
    logic data_hazard;
    logic inst_hazard;
    logic rd_accept_data;
    logic rd_accept_inst;
    logic wr_accept;
    logic r_beat;
    logic r_beat_data;
    logic r_beat_inst;

    assign data_rd_req = bus.data_req && !bus.data_wr;
    assign data_wr_req = bus.data_req && bus.data_wr;

    // A read to the word of an in-flight store must wait for the store to retire.
    assign data_hazard = !wr_idle && (bus.data_addr[ADDR_W-1:2] == wr_addr[ADDR_W-1:2]);
    assign inst_hazard = !wr_idle && (bus.inst_addr[ADDR_W-1:2] == wr_addr[ADDR_W-1:2]);

    // Data loads own the grant whenever present, even if hazard-stalled.
    assign rd_accept_data = !reset && (rd_state_q == R_IDLE) && data_rd_req && !data_hazard;
    assign rd_accept_inst = !reset && (rd_state_q == R_IDLE) && bus.inst_req
                            && !data_rd_req && !inst_hazard;
    assign wr_accept      = !reset && wr_idle && data_wr_req;

    assign r_beat      = (rd_state_q == R_DATA) && bus.rvalid;
    assign r_beat_data = r_beat && (owner_q == OWN_DATA);
    assign r_beat_inst = r_beat && (owner_q == OWN_INST);

    // Read FSM: latch the winning request, issue AR, wait for the R beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q <= R_IDLE;
            owner_q    <= OWN_INST;
            araddr_q   <= '0;
            arsize_q   <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (rd_accept_data) begin
                        owner_q    <= OWN_DATA;
                        araddr_q   <= bus.data_addr;
                        arsize_q   <= bus.data_size;
                        arvalid_q  <= 1'b1;
                        rd_state_q <= R_ADDR;
                    end else if (rd_accept_inst) begin
                        owner_q    <= OWN_INST;
                        araddr_q   <= bus.inst_addr;
                        arsize_q   <= bus.inst_size;
                        arvalid_q  <= 1'b1;
                        rd_state_q <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (bus.arready) begin
                        arvalid_q  <= 1'b0;
                        rready_q   <= 1'b1;
                        rd_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (bus.rvalid) begin
                        rready_q   <= 1'b0;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    sram_axi_arbiter_wr_channel u_wr (
        .clk       (clk),
        .reset     (reset),
        .accept    (wr_accept),
        .req_addr  (bus.data_addr),
        .req_size  (bus.data_size),
        .req_wstrb (bus.data_wstrb),
        .req_wdata (bus.data_wdata),
        .b_block   (r_beat_data),
        .idle      (wr_idle),
        .done      (wr_done),
        .awaddr    (wr_addr),
        .awsize    (bus.awsize),
        .awvalid   (bus.awvalid),
        .awready   (bus.awready),
        .wdata     (bus.wdata),
        .wstrb     (bus.wstrb),
        .wvalid    (bus.wvalid),
        .wready    (bus.wready),
        .bvalid    (bus.bvalid),
        .bready    (bus.bready)
    );

    assign bus.awaddr = wr_addr;

    // SRAM-side handshakes
    assign bus.inst_addr_ok = rd_accept_inst;
    assign bus.data_addr_ok = rd_accept_data || wr_accept;
    assign bus.inst_data_ok = r_beat_inst;
    assign bus.data_data_ok = r_beat_data || wr_done;
    assign bus.inst_rdata   = r_beat_inst ? bus.rdata : '0;
    assign bus.data_rdata   = r_beat_data ? bus.rdata : '0;

    // AXI read channel
    assign bus.araddr  = araddr_q;
    assign bus.arsize  = to_axsize(arsize_q);
    assign bus.arvalid = arvalid_q;
    assign bus.rready  = rready_q;

    // Fixed AXI fields
    assign bus.arid    = AXI_ID;
    assign bus.arlen   = AXI_LEN;
    assign bus.arburst = AXI_BURST_INCR;
    assign bus.awid    = AXI_ID;
    assign bus.awlen   = AXI_LEN;
    assign bus.awburst = AXI_BURST_INCR;
    assign bus.wid     = AXI_ID;
    assign bus.wlast   = AXI_LAST;

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Directed bench for sram_axi_arbiter: stimulus pushes expectations into
// queues; negedge monitors pop and compare on every DUT handshake.
module tb_sram_axi_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sram_axi_arbiter_if bus ();

    sram_axi_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        is_rd;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
    } ax_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_t;

    resp_t inst_exp_q[$];
    resp_t data_exp_q[$];
    ax_t   ar_exp_q[$];
    ax_t   aw_exp_q[$];
    w_t    w_exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitors: compare against the scoreboard whenever the DUT presents a response.
    resp_t ie, de;
    ax_t   ae, we_ax;
    w_t    wd;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.inst_data_ok) begin
                if (inst_exp_q.size() == 0) begin
                    check("spurious inst_data_ok", {31'b0, bus.inst_data_ok}, 32'd0);
                end else begin
                    ie = inst_exp_q.pop_front();
                    check("inst_rdata", bus.inst_rdata, ie.rdata);
                    check("inst_data_ok on R beat", {31'b0, bus.rvalid & bus.rready}, 32'd1);
                end
            end
            if (bus.data_data_ok) begin
                if (data_exp_q.size() == 0) begin
                    check("spurious data_data_ok", {31'b0, bus.data_data_ok}, 32'd0);
                end else begin
                    de = data_exp_q.pop_front();
                    if (de.is_rd) begin
                        check("data_rdata", bus.data_rdata, de.rdata);
                        check("load ok on R beat", {31'b0, bus.rvalid & bus.rready}, 32'd1);
                    end else begin
                        check("store ok on B beat", {31'b0, bus.bvalid & bus.bready}, 32'd1);
                    end
                end
            end
            if (bus.arvalid && bus.arready) begin
                if (ar_exp_q.size() == 0) begin
                    check("spurious AR", bus.araddr, 32'hffff_ffff);
                end else begin
                    ae = ar_exp_q.pop_front();
                    check("araddr", bus.araddr, ae.addr);
                    check("arsize", {29'b0, bus.arsize}, {29'b0, ae.size});
                end
            end
            if (bus.awvalid && bus.awready) begin
                if (aw_exp_q.size() == 0) begin
                    check("spurious AW", bus.awaddr, 32'hffff_ffff);
                end else begin
                    we_ax = aw_exp_q.pop_front();
                    check("awaddr", bus.awaddr, we_ax.addr);
                    check("awsize", {29'b0, bus.awsize}, {29'b0, we_ax.size});
                end
            end
            if (bus.wvalid && bus.wready) begin
                if (w_exp_q.size() == 0) begin
                    check("spurious W", bus.wdata, 32'hffff_ffff);
                end else begin
                    wd = w_exp_q.pop_front();
                    check("wdata", bus.wdata, wd.data);
                    check("wstrb", {28'b0, bus.wstrb}, {28'b0, wd.strb});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.inst_req   = 1'b0;
        bus.inst_size  = 2'd0;
        bus.inst_addr  = '0;
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_size  = 2'd0;
        bus.data_wstrb = '0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
        bus.arready    = 1'b0;
        bus.rdata      = '0;
        bus.rvalid     = 1'b0;
        bus.awready    = 1'b0;
        bus.wready     = 1'b0;
        bus.bvalid     = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr);
        bus.inst_req  = 1'b1;
        bus.inst_size = 2'd2;
        bus.inst_addr = addr;
    endtask

    task automatic load(input logic [31:0] addr);
        bus.data_req  = 1'b1;
        bus.data_wr   = 1'b0;
        bus.data_size = 2'd2;
        bus.data_addr = addr;
    endtask

    task automatic store(input logic [31:0] addr, input logic [1:0] size,
                         input logic [3:0] strb, input logic [31:0] data);
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_size  = size;
        bus.data_addr  = addr;
        bus.data_wstrb = strb;
        bus.data_wdata = data;
        aw_exp_q.push_back('{addr: addr, size: {1'b0, size}});
        w_exp_q.push_back('{data: data, strb: strb});
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        #2;
        // Reset state
        check("rst arvalid", {31'b0, bus.arvalid}, 32'd0);
        check("rst awvalid", {31'b0, bus.awvalid}, 32'd0);
        check("rst wvalid", {31'b0, bus.wvalid}, 32'd0);
        check("rst rready", {31'b0, bus.rready}, 32'd0);
        check("rst bready", {31'b0, bus.bready}, 32'd0);
        check("rst araddr", bus.araddr, 32'd0);
        check("rst awaddr", bus.awaddr, 32'd0);
        check("rst wdata", bus.wdata, 32'd0);
        check("rst oks", {28'b0, bus.inst_addr_ok, bus.inst_data_ok,
                          bus.data_addr_ok, bus.data_data_ok}, 32'd0);
        check("tie arlen/arburst/wlast", {25'b0, bus.arlen, bus.arburst, bus.wlast}, 32'h3);
        step();
        reset = 1'b0;

        // Lone fetch
        step();
        fetch(32'h1fc0_0000);
        #2;
        check("t1 inst_addr_ok", {31'b0, bus.inst_addr_ok}, 32'd1);
        check("t1 data_addr_ok", {31'b0, bus.data_addr_ok}, 32'd0);
        ar_exp_q.push_back('{addr: 32'h1fc0_0000, size: 3'd2});
        inst_exp_q.push_back('{is_rd: 1'b1, rdata: 32'h2401_0001});
        step();
        bus.inst_req = 1'b0;
        bus.arready  = 1'b1;
        #2;
        check("t1 arvalid", {31'b0, bus.arvalid}, 32'd1);
        step();
        bus.arready = 1'b0;
        #2;
        check("t1 arvalid dropped", {31'b0, bus.arvalid}, 32'd0);
        check("t1 rready", {31'b0, bus.rready}, 32'd1);
        step();
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h2401_0001;
        #2;
        check("t1 inst_data_ok", {31'b0, bus.inst_data_ok}, 32'd1);
        step();
        bus.rvalid = 1'b0;

        // Conflict: data load beats fetch
        step();
        fetch(32'h1fc0_0010);
        load(32'h0000_1000);
        #2;
        check("t2 data_addr_ok", {31'b0, bus.data_addr_ok}, 32'd1);
        check("t2 inst_addr_ok", {31'b0, bus.inst_addr_ok}, 32'd0);
        ar_exp_q.push_back('{addr: 32'h0000_1000, size: 3'd2});
        ar_exp_q.push_back('{addr: 32'h1fc0_0010, size: 3'd2});
        data_exp_q.push_back('{is_rd: 1'b1, rdata: 32'h1111_1111});
        inst_exp_q.push_back('{is_rd: 1'b1, rdata: 32'h2222_2222});
        step();
        bus.data_req = 1'b0;
        bus.arready  = 1'b1;
        #2;
        check("t2 inst wait R_ADDR", {31'b0, bus.inst_addr_ok}, 32'd0);
        step();
        bus.arready = 1'b0;
        step();
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h1111_1111;
        #2;
        check("t2 inst wait R beat", {31'b0, bus.inst_addr_ok}, 32'd0);
        step();
        bus.rvalid = 1'b0;
        #2;
        check("t2 inst accepted after beat", {31'b0, bus.inst_addr_ok}, 32'd1);
        step();
        bus.inst_req = 1'b0;
        bus.arready  = 1'b1;
        step();
        bus.arready = 1'b0;
        step();
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h2222_2222;
        step();
        bus.rvalid = 1'b0;

        // Store with split AW/W handshakes
        step();
        store(32'h0000_2002, 2'd1, 4'h3, 32'hdead_beef);
        #2;
        check("t3 data_addr_ok", {31'b0, bus.data_addr_ok}, 32'd1);
        data_exp_q.push_back('{is_rd: 1'b0, rdata: 32'h0});
        step();
        bus.data_req = 1'b0;
        bus.awready  = 1'b1;
        #2;
        check("t3 aw+w valid", {30'b0, bus.awvalid, bus.wvalid}, 32'd3);
        step();
        bus.awready = 1'b0;
        #2;
        check("t3 aw dropped w held", {30'b0, bus.awvalid, bus.wvalid}, 32'd1);
        step();
        bus.wready = 1'b1;
        #2;
        check("t3 bready before W done", {31'b0, bus.bready}, 32'd0);
        step();
        bus.wready = 1'b0;
        #2;
        check("t3 w dropped, bready", {30'b0, bus.wvalid, bus.bready}, 32'd1);
        check("t3 no early data_data_ok", {31'b0, bus.data_data_ok}, 32'd0);
        step();
        bus.bvalid = 1'b1;
        step();
        bus.bvalid = 1'b0;
        #2;
        check("t3 bready after B", {31'b0, bus.bready}, 32'd0);

        // RAW: same word blocked until the store retires
        step();
        store(32'h0000_3000, 2'd2, 4'hf, 32'h55aa_55aa);
        #2;
        check("t4 store accepted", {31'b0, bus.data_addr_ok}, 32'd1);
        data_exp_q.push_back('{is_rd: 1'b0, rdata: 32'h0});
        step();
        load(32'h0000_3000);
        bus.awready = 1'b1;
        bus.wready  = 1'b1;
        #2;
        check("t4 RAW blocked W_REQ", {31'b0, bus.data_addr_ok}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            bus.awready = 1'b0;
            bus.wready  = 1'b0;
            #2;
            check("t4 RAW blocked W_RESP", {31'b0, bus.data_addr_ok}, 32'd0);
        end
        step();
        bus.bvalid = 1'b1;
        #2;
        check("t4 RAW blocked on B", {31'b0, bus.data_addr_ok}, 32'd0);
        step();
        bus.bvalid = 1'b0;
        #2;
        check("t4 load accepted after store", {31'b0, bus.data_addr_ok}, 32'd1);
        ar_exp_q.push_back('{addr: 32'h0000_3000, size: 3'd2});
        data_exp_q.push_back('{is_rd: 1'b1, rdata: 32'h7777_7777});
        step();
        bus.data_req = 1'b0;
        bus.arready  = 1'b1;
        step();
        bus.arready = 1'b0;
        step();
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h7777_7777;
        step();
        bus.rvalid = 1'b0;

        // Different word: load proceeds under an outstanding store
        step();
        store(32'h0000_3000, 2'd2, 4'hf, 32'h1234_5678);
        step();
        load(32'h0000_3004);
        bus.awready = 1'b1;
        bus.wready  = 1'b1;
        #2;
        check("t4 no-hazard load accepted", {31'b0, bus.data_addr_ok}, 32'd1);
        ar_exp_q.push_back('{addr: 32'h0000_3004, size: 3'd2});
        data_exp_q.push_back('{is_rd: 1'b1, rdata: 32'h3c3c_3c3c});
        data_exp_q.push_back('{is_rd: 1'b0, rdata: 32'h0});
        step();
        bus.data_req = 1'b0;
        bus.awready  = 1'b0;
        bus.wready   = 1'b0;
        bus.arready  = 1'b1;
        step();
        bus.arready = 1'b0;
        step();
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h3c3c_3c3c;
        #2;
        check("t4 bready masked by data R", {31'b0, bus.bready}, 32'd0);
        step();
        bus.rvalid = 1'b0;
        step();
        bus.bvalid = 1'b1;
        #2;
        check("t4 bready", {31'b0, bus.bready}, 32'd1);
        step();
        bus.bvalid = 1'b0;

        // Collision: R beat and B valid in the same cycle
        step();
        store(32'h0000_5000, 2'd2, 4'hf, 32'ha5a5_a5a5);
        step();
        load(32'h0000_4000);
        bus.awready = 1'b1;
        bus.wready  = 1'b1;
        #2;
        check("t5 load accepted", {31'b0, bus.data_addr_ok}, 32'd1);
        ar_exp_q.push_back('{addr: 32'h0000_4000, size: 3'd2});
        data_exp_q.push_back('{is_rd: 1'b1, rdata: 32'h0bad_f00d});
        data_exp_q.push_back('{is_rd: 1'b0, rdata: 32'h0});
        step();
        bus.data_req = 1'b0;
        bus.awready  = 1'b0;
        bus.wready   = 1'b0;
        bus.arready  = 1'b1;
        step();
        bus.arready = 1'b0;
        step();
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h0bad_f00d;
        bus.bvalid = 1'b1;
        #2;
        check("t5 bready held off", {31'b0, bus.bready}, 32'd0);
        check("t5 data_data_ok 1st", {31'b0, bus.data_data_ok}, 32'd1);
        step();
        bus.rvalid = 1'b0;
        #2;
        check("t5 bready released", {31'b0, bus.bready}, 32'd1);
        check("t5 data_data_ok 2nd", {31'b0, bus.data_data_ok}, 32'd1);
        step();
        bus.bvalid = 1'b0;

        // Reset while AR is pending, then a fresh fetch
        step();
        fetch(32'h1fc0_0100);
        #2;
        check("t6 inst_addr_ok", {31'b0, bus.inst_addr_ok}, 32'd1);
        step();
        bus.inst_req = 1'b0;
        reset        = 1'b1;
        #2;
        check("t6 arvalid pre-reset", {31'b0, bus.arvalid}, 32'd1);
        step();
        reset = 1'b0;
        #2;
        check("t6 arvalid after reset", {31'b0, bus.arvalid}, 32'd0);
        check("t6 oks after reset", {28'b0, bus.inst_addr_ok, bus.inst_data_ok,
                                     bus.data_addr_ok, bus.data_data_ok}, 32'd0);
        step();
        fetch(32'h1fc0_0000);
        #2;
        check("t6 fresh fetch accepted", {31'b0, bus.inst_addr_ok}, 32'd1);
        ar_exp_q.push_back('{addr: 32'h1fc0_0000, size: 3'd2});
        inst_exp_q.push_back('{is_rd: 1'b1, rdata: 32'haaaa_5555});
        step();
        bus.inst_req = 1'b0;
        bus.arready  = 1'b1;
        step();
        bus.arready = 1'b0;
        step();
        bus.rvalid = 1'b1;
        bus.rdata  = 32'haaaa_5555;
        step();
        bus.rvalid = 1'b0;
        step();
        step();

        // Every expected response must have been consumed
        check("inst queue drained", inst_exp_q.size(), 32'd0);
        check("data queue drained", data_exp_q.size(), 32'd0);
        check("ar queue drained", ar_exp_q.size(), 32'd0);
        check("aw queue drained", aw_exp_q.size(), 32'd0);
        check("w queue drained", w_exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
